regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port register file; successor to the single-issue 2R/1W MIPS register file.
- Provides NUM_RD combinational read ports and 2 synchronous write ports for a dual-issue decode/writeback stage.
- Write-to-read bypass is configurable.
- Includes a hardware clear engine that zeroes every register after reset or on request; `ready` tells the pipeline when the file holds valid state.

Parameters:
- DATA_W, 32: register width in bits.
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W registers.
- NUM_RD, 2: number of read ports (1..8).
- ZERO_REG, 1: 1 = register 0 always reads 0 and ignores writes.
- BYPASS, 1: 1 = a same-cycle write is forwarded to a matching read.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- init_req  in  1  pulse; starts a full clear sequence when ready=1.
- ready  out  1  1 = clear complete, reads and writes valid.
- we0  in  1  write enable, port 0.
- waddr0  in  ADDR_W  write address, port 0.
- wdata0  in  DATA_W  write data, port 0.
- we1  in  1  write enable, port 1 (younger instruction).
- waddr1  in  ADDR_W  write address, port 1.
- wdata1  in  DATA_W  write data, port 1.
- re  in  NUM_RD  per-port read enable; bit i = port i.
- raddr  in  NUM_RD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W].
- rdata  out  NUM_RD*DATA_W  read data; port i at bits [i*DATA_W +: DATA_W].

Behaviour:
- State machine: CLEAR, READY. Clear counter clr_cnt is ADDR_W bits.
- Reset: rst=0 at a clock edge gives state=CLEAR, clr_cnt=0, ready=0. Array contents are not touched while rst=0.
- CLEAR, each edge with rst=1:
  - regs[clr_cnt] <= 0; clr_cnt++.
  - When clr_cnt==DEPTH-1, the final write occurs and state moves to READY, ready<=1.
  - ready therefore rises exactly DEPTH edges after rst is released (32 with defaults).
- READY:
  - init_req=1 at an edge gives state=CLEAR, clr_cnt=0, ready=0.
  - User writes on that same edge are still performed, then overwritten by the clear.
  - init_req is ignored in CLEAR (no restart).
- Reset mid-clear: the counter returns to 0 and the sequence restarts; DEPTH further edges are needed.
- Writes (READY only; we0/we1 ignored in CLEAR and while rst=0):
  - Port 0 writes regs[waddr0]<=wdata0 if we0.
  - Port 1 writes regs[waddr1]<=wdata1 if we1.
  - waddr0==waddr1 with both enabled: port 1 wins.
  - ZERO_REG=1: writes to address 0 are dropped.
- Read port i (combinational), first match wins:
  1. rst==0 or ready==0 -> 0.
  2. re[i]==0 -> 0.
  3. ZERO_REG and raddr_i==0 -> 0.
  4. BYPASS and we1 and waddr1==raddr_i -> wdata1.
  5. BYPASS and we0 and waddr0==raddr_i -> wdata0.
  6. Otherwise regs[raddr_i].
- Without BYPASS, a written value is visible on reads in the cycle after the write edge.
- Read ports are fully independent; any number may address the same register.
- No read-side state; read latency is 0 cycles.

Test Plan:
- Reset clear: rst=0 for 2 cycles, then 1 -> ready=0 for 32 edges, ready=1 after the 32nd; all 32 regs read 0 with re=all-1.
- Write/readback: we0 r5=0xDEADBEEF, we1 r6=0x12345678 in one cycle -> next cycle rdata0(r5)=0xDEADBEEF, rdata1(r6)=0x12345678.
- Bypass and priority: we0 r7=0x1, we1 r7=0x2, raddr0=7 in the same cycle -> rdata0=0x2 combinationally; next cycle r7 reads 0x2.
  - BYPASS=0 build: the same-cycle read returns the old r7 value.
- Zero register: we0 r0=0xFFFFFFFF -> r0 reads 0 in the same and next cycle.
  - ZERO_REG=0 build: next cycle r0 reads 0xFFFFFFFF.
- Re-init: r9=0xA5A5A5A5, pulse init_req -> ready=0 next cycle, we0 ignored during clear, ready=1 after 32 edges, r9 reads 0.
- Reset mid-clear: assert rst=0 at clear edge 10 -> after release, ready returns only after 32 more edges; re=0 on any port -> that port reads 0.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two write ports,
// optional write-to-read bypass and a hardware clear engine gating `ready`.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     init_req,
    output logic                     ready,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_next;
    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr0_ok, wr1_ok;

    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        case (state)
            CLEAR: begin
                clr_cnt_next = clr_cnt + ADDR_W'(1);
                if (clr_cnt == '1) begin
                    state_next = READY;
                end
            end
            READY: begin
                if (init_req) begin
                    state_next   = CLEAR;
                    clr_cnt_next = '0;
                end
            end
            default: begin
                state_next   = CLEAR;
                clr_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
        end
    end

    assign ready = (state == READY);

    assign wr0_ok = we0 && !((ZERO_REG != 0) && (waddr0 == '0));
    assign wr1_ok = we1 && !((ZERO_REG != 0) && (waddr1 == '0));

    // Port 1 is issued after port 0 so it wins on an address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state == CLEAR) begin
                regs[clr_cnt] <= '0;
            end else begin
                if (wr0_ok) regs[waddr0] <= wdata0;
                if (wr1_ok) regs[waddr1] <= wdata1;
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;

        assign ra = raddr[i*ADDR_W +: ADDR_W];

        always_comb begin
            rd = '0;
            if (!rst || !ready || !re[i]) begin
                rd = '0;
            end else if ((ZERO_REG != 0) && (ra == '0)) begin
                rd = '0;
            end else if ((BYPASS != 0) && we1 && (waddr1 == ra)) begin
                rd = wdata1;
            end else if ((BYPASS != 0) && we0 && (waddr0 == ra)) begin
                rd = wdata0;
            end else begin
                rd = regs[ra];
            end
        end

        assign rdata[i*DATA_W +: DATA_W] = rd;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default build plus a BYPASS=0/ZERO_REG=0 build
// sharing the same stimulus.
module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic        init_req;
    logic        ready, ready_alt;
    logic        we0, we1;
    logic [4:0]  waddr0, waddr1;
    logic [31:0] wdata0, wdata1;
    logic [1:0]  re;
    logic [9:0]  raddr;
    logic [63:0] rdata, rdata_alt;

    int checks = 0;
    int errors = 0;

    regfile_mp u_dut (
        .clk(clk), .rst(rst), .init_req(init_req), .ready(ready),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .re(re), .raddr(raddr), .rdata(rdata)
    );

    regfile_mp #(.BYPASS(0), .ZERO_REG(0)) u_alt (
        .clk(clk), .rst(rst), .init_req(init_req), .ready(ready_alt),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .re(re), .raddr(raddr), .rdata(rdata_alt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ready(input string tag, input logic exp);
        chk({tag, "_ready"}, {31'd0, ready}, {31'd0, exp});
        chk({tag, "_ready_alt"}, {31'd0, ready_alt}, {31'd0, exp});
    endtask

    initial begin
        rst = 1'b0; init_req = 1'b0;
        we0 = 1'b0; we1 = 1'b0; waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
        re = 2'b11; raddr = '0;

        // Reset held for two edges
        step(); step();
        #1;
        chk_ready("rst_low", 1'b0);
        chk("rst_low_rd0", rdata[31:0], 32'h0);
        chk("rst_low_rd1_alt", rdata_alt[63:32], 32'h0);

        rst = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            step();
            chk_ready("clr_edge", (k == 32));
        end

        // Whole file reads zero
        re = 2'b11;
        for (int a = 0; a < 32; a += 2) begin
            raddr[4:0] = 5'(a);
            raddr[9:5] = 5'(a + 1);
            #1;
            chk("clr_rd0", rdata[31:0], 32'h0);
            chk("clr_rd1", rdata[63:32], 32'h0);
            chk("clr_rd0_alt", rdata_alt[31:0], 32'h0);
            chk("clr_rd1_alt", rdata_alt[63:32], 32'h0);
        end

        // Dual write then readback
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
        we1 = 1'b1; waddr1 = 5'd6; wdata1 = 32'h12345678;
        raddr = {5'd6, 5'd5};
        step();
        we0 = 1'b0; we1 = 1'b0;
        #1;
        chk("wr_rd0", rdata[31:0], 32'hDEADBEEF);
        chk("wr_rd1", rdata[63:32], 32'h12345678);
        chk("wr_rd0_alt", rdata_alt[31:0], 32'hDEADBEEF);
        chk("wr_rd1_alt", rdata_alt[63:32], 32'h12345678);

        // Same-address collision, same-cycle read
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h1;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h2;
        raddr = {5'd5, 5'd7};
        #1;
        chk("byp_rd0", rdata[31:0], 32'h2);
        chk("byp_rd1", rdata[63:32], 32'hDEADBEEF);
        chk("nobyp_rd0_alt", rdata_alt[31:0], 32'h0);
        step();
        we0 = 1'b0; we1 = 1'b0;
        #1;
        chk("prio_rd0", rdata[31:0], 32'h2);
        chk("prio_rd0_alt", rdata_alt[31:0], 32'h2);

        // Register zero
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF;
        raddr = {5'd0, 5'd0};
        #1;
        chk("r0_same", rdata[31:0], 32'h0);
        chk("r0_same_alt", rdata_alt[31:0], 32'h0);
        step();
        we0 = 1'b0;
        #1;
        chk("r0_next", rdata[63:32], 32'h0);
        chk("r0_next_alt", rdata_alt[63:32], 32'hFFFFFFFF);

        // Re-init with writes attempted during the clear
        we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'hA5A5A5A5;
        step();
        we0 = 1'b0;
        raddr = {5'd9, 5'd9};
        #1;
        chk("r9_pre", rdata[31:0], 32'hA5A5A5A5);
        init_req = 1'b1;
        step();
        init_req = 1'b0;
        we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h55;
        #1;
        chk_ready("init", 1'b0);
        chk("init_rd", rdata[31:0], 32'h0);
        for (int k = 1; k <= 32; k++) begin
            step();
            if (k == 4) init_req = 1'b1;
            if (k == 5) init_req = 1'b0;
            if (k == 31) we0 = 1'b0;
            #1;
            chk_ready("reinit_edge", (k == 32));
        end
        chk("r9_cleared", rdata[31:0], 32'h0);
        chk("r9_cleared_alt", rdata_alt[63:32], 32'h0);

        // Reset arriving at clear edge 10 restarts the sequence
        init_req = 1'b1;
        step();
        init_req = 1'b0;
        for (int k = 1; k <= 9; k++) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk_ready("midclr", 1'b0);
        for (int k = 1; k <= 32; k++) begin
            step();
            chk_ready("restart_edge", (k == 32));
        end

        // Per-port read enable
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hCAFEF00D;
        step();
        we0 = 1'b0;
        raddr = {5'd5, 5'd5};
        re = 2'b01;
        #1;
        chk("re01_rd0", rdata[31:0], 32'hCAFEF00D);
        chk("re01_rd1", rdata[63:32], 32'h0);
        re = 2'b10;
        #1;
        chk("re10_rd0", rdata[31:0], 32'h0);
        chk("re10_rd1", rdata[63:32], 32'hCAFEF00D);
        chk("re10_rd1_alt", rdata_alt[63:32], 32'hCAFEF00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
